// File: rtl/sdes_seq_core.sv
// sdes_seq_core: round-sequenced S-DES encrypt/decrypt engine with a start/done handshake.
// Define SDES_KEY_CACHE_EN to keep the last key schedule and skip KEYGEN when the key repeats.
module sdes_seq_core #(
   parameter bit DOUT_HOLD = 1'b1
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       start,
   input  logic       mode,
   input  logic [9:0] key_in,
   input  logic [7:0] data_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] data_out,
   output logic [7:0] k1_out,
   output logic [7:0] k2_out
);
   typedef enum logic [2:0] {IDLE, KEYGEN, PERM, ROUND1, ROUND2, OUTP} state_t;

   // S-box tables: 2-bit entry at index {row, col}, row = outer bits, col = inner bits
   localparam logic [31:0] S0_T = 32'b10110111_11011000_00011011_10110001;
   localparam logic [31:0] S1_T = 32'b11000110_00010011_11010010_11100100;

   state_t     state_q, state_d;
   logic       mode_q, mode_d, done_q, done_d, hit;
   logic [9:0] key_q, key_d, p10k;
   logic [7:0] data_q, data_d, blk_q, blk_d, k1_q, k1_d, k2_q, k2_d, dout_q, dout_d;
   logic [7:0] rkey, fk_o;
`ifdef SDES_KEY_CACHE_EN
   logic       cache_q, cache_d;
`endif

   function automatic logic [9:0] p10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   function automatic logic [9:0] ls1(input logic [9:0] x);
      return {x[8:5], x[9], x[3:0], x[4]};
   endfunction

   function automatic logic [7:0] p8(input logic [9:0] x);
      return {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
   endfunction

   function automatic logic [7:0] ip(input logic [7:0] d);
      return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
   endfunction

   function automatic logic [7:0] ip_inv(input logic [7:0] d);
      return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
   endfunction

   function automatic logic [7:0] fk(input logic [7:0] b, input logic [7:0] k);
      logic [7:0] t;
      logic [3:0] s;
      t = {b[0], b[3], b[2], b[1], b[2], b[1], b[0], b[3]} ^ k;
      s = {S0_T[{t[7], t[4], t[6], t[5], 1'b0} +: 2], S1_T[{t[3], t[0], t[2], t[1], 1'b0} +: 2]};
      return {b[7:4] ^ {s[2], s[0], s[1], s[3]}, b[3:0]};
   endfunction

   // Single shared round: ROUND1 uses the first key of the mode's order, ROUND2 the other
   assign rkey = (mode_q ^ (state_q == ROUND2)) ? k2_q : k1_q;
   assign fk_o = fk(blk_q, rkey);
   assign p10k = p10(key_q);
`ifdef SDES_KEY_CACHE_EN
   assign hit  = cache_q && (key_in == key_q);
`else
   assign hit  = 1'b0;
`endif

   assign busy     = state_q != IDLE;
   assign done     = done_q;
   assign data_out = dout_q;
   assign k1_out   = k1_q;
   assign k2_out   = k2_q;

   // Next-state and datapath sequencing: capture, key schedule, IP, two rounds, IP^-1
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      key_d   = key_q;
      data_d  = data_q;
      blk_d   = blk_q;
      k1_d    = k1_q;
      k2_d    = k2_q;
      dout_d  = DOUT_HOLD ? dout_q : 8'd0;
      done_d  = 1'b0;
`ifdef SDES_KEY_CACHE_EN
      cache_d = cache_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            mode_d  = mode;
            key_d   = key_in;
            data_d  = data_in;
            state_d = hit ? PERM : KEYGEN;
         end
         KEYGEN: begin
            k1_d    = p8(ls1(p10k));
            k2_d    = p8(ls1(ls1(ls1(p10k))));
            state_d = PERM;
`ifdef SDES_KEY_CACHE_EN
            cache_d = 1'b1;
`endif
         end
         PERM: begin
            blk_d   = ip(data_q);
            state_d = ROUND1;
         end
         ROUND1: begin
            blk_d   = {fk_o[3:0], fk_o[7:4]};
            state_d = ROUND2;
         end
         ROUND2: begin
            blk_d   = fk_o;
            state_d = OUTP;
         end
         OUTP: begin
            dout_d  = ip_inv(blk_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation silently
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         key_q   <= 10'd0;
         data_q  <= 8'd0;
         blk_q   <= 8'd0;
         k1_q    <= 8'd0;
         k2_q    <= 8'd0;
         dout_q  <= 8'd0;
         done_q  <= 1'b0;
`ifdef SDES_KEY_CACHE_EN
         cache_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         key_q   <= key_d;
         data_q  <= data_d;
         blk_q   <= blk_d;
         k1_q    <= k1_d;
         k2_q    <= k2_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
`ifdef SDES_KEY_CACHE_EN
         cache_q <= cache_d;
`endif
      end
   end
endmodule

// File: tb/tb_sdes_seq_core.sv
// tb_sdes_seq_core: randomized self-checking bench against a table-driven S-DES model.
module tb_sdes_seq_core;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic [9:0] key = 10'd0;
   logic [7:0] data = 8'd0;
   logic       busy_h, done_h, busy_z, done_z;
   logic [7:0] dout_h, k1_h, k2_h, dout_z, k1_z, k2_z;
   int         checks = 0, errors = 0;
   logic       mc_valid = 1'b0;
   logic [9:0] mc_key = 10'd0;

   int P10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   int P8[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
   int IPT[10] = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
   int IPI[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
   int EPT[10] = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
   int P4T[10] = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
   logic [1:0] S0[4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2}, '{2'd3, 2'd2, 2'd1, 2'd0},
                            '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd3, 2'd1, 2'd3, 2'd2}};
   logic [1:0] S1[4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd2, 2'd0, 2'd1, 2'd3},
                            '{2'd3, 2'd0, 2'd1, 2'd0}, '{2'd2, 2'd1, 2'd0, 2'd3}};

   sdes_seq_core #(.DOUT_HOLD(1'b1)) u_hold (
      .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .mode(mode), .key_in(key), .data_in(data),
      .busy(busy_h), .done(done_h), .data_out(dout_h), .k1_out(k1_h), .k2_out(k2_h));
   sdes_seq_core #(.DOUT_HOLD(1'b0)) u_zero (
      .CLOCK_50(clk), .RESET_N(rst_n), .start(start), .mode(mode), .key_in(key), .data_in(data),
      .busy(busy_z), .done(done_z), .data_out(dout_z), .k1_out(k1_z), .k2_out(k2_z));

   always #5 clk = ~clk;

   function automatic logic [9:0] perm(input logic [9:0] x, input int n, input int t[10], input int m);
      logic [9:0] r = 10'd0;
      for (int i = 0; i < m; i++) r = {r[8:0], x[n - t[i]]};
      return r;
   endfunction

   function automatic logic [4:0] rol5(input logic [4:0] v, input int n);
      for (int i = 0; i < n; i++) v = {v[3:0], v[4]};
      return v;
   endfunction

   task automatic model(input logic [9:0] k, input logic [7:0] d, input logic m,
                        output logic [7:0] k1, output logic [7:0] k2, output logic [7:0] o);
      logic [9:0] p, v;
      logic [4:0] l, r;
      logic [7:0] b, t;
      logic [7:0] rk[2];
      logic [3:0] lh, rh, f;
      logic [1:0] a, c;
      p = perm(k, 10, P10, 10);
      l = rol5(p[9:5], 1);
      r = rol5(p[4:0], 1);
      v = perm({l, r}, 10, P8, 8);
      k1 = v[7:0];
      l = rol5(l, 2);
      r = rol5(r, 2);
      v = perm({l, r}, 10, P8, 8);
      k2 = v[7:0];
      rk[0] = m ? k2 : k1;
      rk[1] = m ? k1 : k2;
      v = perm({2'b00, d}, 8, IPT, 8);
      b = v[7:0];
      for (int i = 0; i < 2; i++) begin
         lh = b[7:4];
         rh = b[3:0];
         v = perm({6'd0, rh}, 4, EPT, 8);
         t = v[7:0] ^ rk[i];
         a = S0[{t[7], t[4]}][{t[6], t[5]}];
         c = S1[{t[3], t[0]}][{t[2], t[1]}];
         v = perm({6'd0, a, c}, 4, P4T, 4);
         f = v[3:0];
         lh = lh ^ f;
         b = (i == 0) ? {rh, lh} : {lh, rh};
      end
      v = perm({2'b00, b}, 8, IPI, 8);
      o = v[7:0];
   endtask

   // Expected start-to-done latency; also tracks the key cache when it is built in
   function automatic int exp_lat(input logic [9:0] k);
`ifdef SDES_KEY_CACHE_EN
      if (mc_valid && k == mc_key) return 4;
      mc_valid = 1'b1;
      mc_key = k;
`endif
      return 5;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm, input int c0, input int lat,
                            input logic [7:0] eo, input logic [7:0] ek1, input logic [7:0] ek2);
      int c = c0, nb = c0;
      while (!done_h && c < 20) begin
         if (busy_h) nb++;
         tick();
         c++;
      end
      checks++;
      if (c != lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", nm, c, lat); end
      checks++;
      if (nb != lat) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, nb, lat); end
      checks++;
      if (busy_h !== 1'b0) begin errors++; $display("FAIL %s busy_in_done: got %b expected 0", nm, busy_h); end
      checks++;
      if (dout_h !== eo) begin errors++; $display("FAIL %s data_out: got %h expected %h", nm, dout_h, eo); end
      checks++;
      if (done_z !== 1'b1 || dout_z !== eo) begin
         errors++; $display("FAIL %s nohold_done: got done=%b data=%h expected 1 %h", nm, done_z, dout_z, eo);
      end
      checks++;
      if (k1_h !== ek1 || k2_h !== ek2) begin
         errors++; $display("FAIL %s subkeys: got %h %h expected %h %h", nm, k1_h, k2_h, ek1, ek2);
      end
   endtask

   task automatic run_op(input string nm, input logic [9:0] k, input logic [7:0] d, input logic m);
      logic [7:0] k1, k2, o;
      int lat;
      model(k, d, m, k1, k2, o);
      lat = exp_lat(k);
      key = k; data = d; mode = m; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(nm, 0, lat, o, k1, k2);
      tick();
      checks++;
      if (done_h !== 1'b0 || dout_h !== o || dout_z !== 8'd0) begin
         errors++;
         $display("FAIL %s after_done: got done=%b hold=%h zero=%h expected 0 %h 00", nm, done_h, dout_h, dout_z, o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0;
      tick();
      tick();
      checks++;
      if ({busy_h, done_h, dout_h, k1_h, k2_h} !== 26'd0) begin
         errors++; $display("FAIL reset_hold: got %h expected 0", {busy_h, done_h, dout_h, k1_h, k2_h});
      end
      checks++;
      if ({busy_z, done_z, dout_z, k1_z, k2_z} !== 26'd0) begin
         errors++; $display("FAIL reset_zero: got %h expected 0", {busy_z, done_z, dout_z, k1_z, k2_z});
      end
      rst_n = 1'b1;
      mc_valid = 1'b0;
      tick();
   endtask

   task automatic test_known();
      run_op("known_enc", 10'b1010000010, 8'b10010111, 1'b0);
      checks++;
      if (dout_h !== 8'b00111000 || k1_h !== 8'b10100100 || k2_h !== 8'b01000011) begin
         errors++; $display("FAIL known_enc_const: got %b %b %b expected 00111000 10100100 01000011", dout_h, k1_h, k2_h);
      end
      run_op("known_dec", 10'b1010000010, 8'b00111000, 1'b1);
      checks++;
      if (dout_h !== 8'b10010111) begin
         errors++; $display("FAIL known_dec_const: got %b expected 10010111", dout_h);
      end
   endtask

   task automatic test_cache();
      logic [31:0] r = $urandom();
      logic [9:0] k = r[9:0] ^ mc_key ^ 10'h001;
      run_op("cache_first", k, r[17:10], r[18]);
      run_op("cache_repeat", k, r[25:18], r[26]);
      run_op("cache_newkey", k ^ 10'h200, r[31:24], 1'b0);
   endtask

   task automatic test_ignore();
      logic [31:0] r = $urandom();
      logic [7:0] k1, k2, o;
      int lat;
      model(r[9:0], r[17:10], r[18], k1, k2, o);
      lat = exp_lat(r[9:0]);
      key = r[9:0]; data = r[17:10]; mode = r[18]; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      key = ~r[9:0]; data = ~r[17:10]; mode = ~r[18]; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ignore", 2, lat, o, k1, k2);
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({done_h, busy_h, dout_h, dout_z} !== {2'b00, o, 8'd0}) begin
            errors++;
            $display("FAIL ignore_quiet[%0d]: got done=%b busy=%b hold=%h zero=%h expected 0 0 %h 00", i, done_h, busy_h, dout_h, dout_z, o);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r = $urandom();
      logic [9:0] k = r[9:0] ^ mc_key ^ 10'h040;
      logic [7:0] k1, k2, o;
      int nxt;
      logic prev = 1'b0, expd;
      model(k, r[17:10], r[18], k1, k2, o);
      nxt = exp_lat(k);
      key = k; data = r[17:10]; mode = r[18]; start = 1'b1;
      tick();
      for (int c = 0; c < 40; c++) begin
         expd = (c == nxt);
         if (expd) nxt += 1 + exp_lat(k);
         checks++;
         if (done_h !== expd || done_z !== expd) begin
            errors++; $display("FAIL b2b_done[%0d]: got %b %b expected %b", c, done_h, done_z, expd);
         end
         checks++;
         if (dout_z !== (expd ? o : 8'd0)) begin
            errors++; $display("FAIL b2b_nohold[%0d]: got %h expected %h", c, dout_z, expd ? o : 8'd0);
         end
         checks++;
         if (prev && done_h) begin
            errors++; $display("FAIL b2b_consecutive[%0d]: got done twice expected single pulse", c);
         end
         prev = done_h;
         tick();
      end
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [9:0] k = 10'd0;
      for (int i = 0; i < 16; i++) begin
         r = $urandom();
         if (i % 3 != 1) k = r[9:0];
         run_op($sformatf("random%0d", i), k, r[17:10], r[18]);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r = $urandom();
      logic [9:0] k = r[9:0] ^ mc_key ^ 10'h2A5;
      key = k; data = r[17:10]; mode = r[18]; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_h, done_h, dout_h, k1_h, k2_h, busy_z, done_z, dout_z, k1_z, k2_z} !== 52'd0) begin
         errors++; $display("FAIL midreset_outputs: got %h %h expected 0", {busy_h, done_h, dout_h, k1_h, k2_h}, {busy_z, done_z, dout_z, k1_z, k2_z});
      end
      tick();
      rst_n = 1'b1;
      mc_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (done_h !== 1'b0 || busy_h !== 1'b0) begin
            errors++; $display("FAIL midreset_quiet[%0d]: got done=%b busy=%b expected 0 0", i, done_h, busy_h);
         end
      end
      run_op("after_reset", k, r[25:18], r[26]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_known();
      test_cache();
      test_ignore();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
